// File: rtl/core_seq_pkg.sv
// core_seq_pkg -- shared types and constants for the NPC instruction sequencer.
// Holds the sequencer state encoding, the default reset PC and the sequential
// PC increment, plus a small helper for the fall-through next-PC computation.

package core_seq_pkg;

    // Sequencer states: one instruction walks FETCH_REQ -> FETCH_WAIT -> EXEC
    // -> COMMIT and then back to FETCH_REQ, or to HALT once ebreak retires.
    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        COMMIT     = 3'd3,
        HALT       = 3'd4
    } state_t;

    // Architectural PC after reset unless the instantiation overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Size of one instruction word in bytes.
    localparam logic [31:0] PC_INC = 32'd4;

    // Fall-through next PC; the add wraps naturally at 2^32.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] cur_pc);
        return cur_pc + PC_INC;
    endfunction

endpackage

// File: rtl/core_seq_dnpc_sel.sv
// core_seq_dnpc_sel -- next-PC priority selector for the sequencer.
// Purely combinational. When several control-flow flags are set together the
// highest priority one wins: ecall, mret, jump, branch, then sequential.

module core_seq_dnpc_sel
    import core_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic        jump_flag,
    input  logic        branch_flag,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] exu_res,
    input  logic [31:0] branch_pc,
    output logic [31:0] dnpc
);

    logic [31:0] dnpc_s;

    // Priority mux: traps first, then trap return, then jumps and branches.
    always_comb begin
        dnpc_s = seq_next_pc(pc);
        if (is_ecall) begin
            dnpc_s = mtvec;
        end else if (is_mret) begin
            dnpc_s = mepc;
        end else if (jump_flag) begin
            dnpc_s = exu_res;
        end else if (branch_flag) begin
            dnpc_s = branch_pc;
        end else begin
            dnpc_s = seq_next_pc(pc);
        end
    end

    assign dnpc = dnpc_s;

endmodule

// File: rtl/core_seq.sv
// core_seq -- multicycle instruction sequencer for the NPC core.
// Owns the architectural PC and steps each instruction through fetch request,
// fetch response, execute and commit. All handshake outputs come straight from
// flops so no input reaches them combinationally.
// Optional feature: define PERF_CNT_EN to build the 64-bit cycle and
// instret counters; without it both counter ports are tied to zero.

module core_seq
    import core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    // fetch request channel
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_addr,
    // fetch response channel
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    // execute control
    output logic        exu_start,
    input  logic        exu_done,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic        jump_flag,
    input  logic        branch_flag,
    input  logic        is_ebreak,
    input  logic [31:0] exu_res,
    input  logic [31:0] branch_pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    // architectural state and status
    output logic [31:0] pc,
    output logic        wb_en,
    output logic        halted,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] dnpc_r;
    logic        ebreak_r;
    logic        req_valid_r;
    logic        rsp_ready_r;
    logic        exu_start_r;
    logic        wb_en_r;
    logic        halted_r;
    logic [31:0] dnpc_s;

    // Next-PC candidate; only captured on the cycle exu_done is accepted.
    core_seq_dnpc_sel u_dnpc_sel (
        .pc          (pc_r),
        .is_ecall    (is_ecall),
        .is_mret     (is_mret),
        .jump_flag   (jump_flag),
        .branch_flag (branch_flag),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .exu_res     (exu_res),
        .branch_pc   (branch_pc),
        .dnpc        (dnpc_s)
    );

    // Sequencer FSM; each branch also sets the output flops for the state it
    // enters, so outputs are registered and line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FETCH_REQ;
            pc_r        <= RESET_PC;
            inst_r      <= 32'd0;
            dnpc_r      <= RESET_PC;
            ebreak_r    <= 1'b0;
            req_valid_r <= 1'b1;
            rsp_ready_r <= 1'b0;
            exu_start_r <= 1'b0;
            wb_en_r     <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            // start and writeback are single-cycle pulses
            exu_start_r <= 1'b0;
            wb_en_r     <= 1'b0;
            case (state_r)
                FETCH_REQ: begin
                    if (ifu_req_ready) begin
                        state_r     <= FETCH_WAIT;
                        req_valid_r <= 1'b0;
                        rsp_ready_r <= 1'b1;
                    end else begin
                        state_r     <= FETCH_REQ;
                        req_valid_r <= 1'b1;
                        rsp_ready_r <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    if (ifu_rsp_valid) begin
                        state_r     <= EXEC;
                        inst_r      <= ifu_rsp_inst;
                        rsp_ready_r <= 1'b0;
                        exu_start_r <= 1'b1;
                    end else begin
                        state_r     <= FETCH_WAIT;
                        rsp_ready_r <= 1'b1;
                    end
                end
                EXEC: begin
                    // a done seen alongside start belongs to a stale op
                    if (exu_done && !exu_start_r) begin
                        state_r  <= COMMIT;
                        dnpc_r   <= dnpc_s;
                        ebreak_r <= is_ebreak;
                        wb_en_r  <= 1'b1;
                    end else begin
                        state_r  <= EXEC;
                    end
                end
                COMMIT: begin
                    pc_r <= dnpc_r;
                    if (ebreak_r) begin
                        state_r     <= HALT;
                        halted_r    <= 1'b1;
                        req_valid_r <= 1'b0;
                    end else begin
                        state_r     <= FETCH_REQ;
                        halted_r    <= 1'b0;
                        req_valid_r <= 1'b1;
                    end
                end
                HALT: begin
                    state_r     <= HALT;
                    halted_r    <= 1'b1;
                    req_valid_r <= 1'b0;
                    rsp_ready_r <= 1'b0;
                end
                default: begin
                    // unreachable encoding: recover to a clean fetch
                    state_r     <= FETCH_REQ;
                    req_valid_r <= 1'b1;
                    rsp_ready_r <= 1'b0;
                    halted_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [63:0] perf_cycle_r;
    logic [63:0] perf_instret_r;

    // Cycle counter runs until halt; instret counts each commit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycle_r   <= 64'd0;
            perf_instret_r <= 64'd0;
        end else begin
            if (state_r != HALT) begin
                perf_cycle_r <= perf_cycle_r + 64'd1;
            end else begin
                perf_cycle_r <= perf_cycle_r;
            end
            if (wb_en_r) begin
                perf_instret_r <= perf_instret_r + 64'd1;
            end else begin
                perf_instret_r <= perf_instret_r;
            end
        end
    end

    assign perf_cycle   = perf_cycle_r;
    assign perf_instret = perf_instret_r;
`else
    assign perf_cycle   = 64'd0;
    assign perf_instret = 64'd0;
`endif

    assign ifu_req_valid = req_valid_r;
    assign ifu_req_addr  = pc_r;
    assign ifu_rsp_ready = rsp_ready_r;
    assign inst          = inst_r;
    assign exu_start     = exu_start_r;
    assign pc            = pc_r;
    assign wb_en         = wb_en_r;
    assign halted        = halted_r;

endmodule
